// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity mode and stop-bit count, majority-voted sampling.
// Latency: valid pulses about BIT_TICKS*(DATA_W+P+STOP_BITS) + (BIT_TICKS-MID) + 3 cycles after the start edge.
// No backpressure: each frame yields a one-cycle valid pulse; rx_data and the error flags hold until the next one.
module uart_rx_cfg #(
    parameter int FCLK      = 100000000,
    parameter int BAUD      = 115200,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              break_det,
    output logic              idle
);

    localparam int BIT_TICKS = FCLK / BAUD;
    localparam int MID       = BIT_TICKS / 2;
    localparam int CW        = $clog2(BIT_TICKS);
    localparam int IW        = $clog2(DATA_W);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [IW-1:0] idx_t;

    localparam cnt_t CNT_TOP  = cnt_t'(BIT_TICKS - 1);
    localparam cnt_t CNT_HI   = cnt_t'(MID + 1);
    localparam cnt_t CNT_MID  = cnt_t'(MID);
    localparam cnt_t CNT_LO   = cnt_t'(MID - 1);
    localparam idx_t IDX_LAST = idx_t'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t            state;
    logic              sync1;
    logic              rx_s;
    logic              rx_d;
    cnt_t              cnt;
    cnt_t              tick_next;
    logic              at_zero;
    logic              decide;
    logic              s_hi;
    logic              s_mid;
    logic              vote;
    idx_t              bit_idx;
    logic              stop_idx;
    logic              last_stop;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              ferr;
    logic              par_calc;
    logic              pe_now;
    logic              brk_par_ok;
    logic              fe_now;

    // Two-flop synchroniser plus one delay stage for falling-edge detection; idle line is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            rx_d  <= rx_s;
        end
    end

    // Capture the first two of the three mid-bit samples; the third is taken live at the decision count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_hi  <= 1'b1;
            s_mid <= 1'b1;
        end else begin
            if (cnt == CNT_HI) begin
                s_hi <= rx_s;
            end
            if (cnt == CNT_MID) begin
                s_mid <= rx_s;
            end
        end
    end

    assign at_zero   = (cnt == '0);
    assign tick_next = at_zero ? CNT_TOP : (cnt - cnt_t'(1));
    assign decide    = (cnt == CNT_LO);
    assign vote      = (s_hi & s_mid) | (s_hi & rx_s) | (s_mid & rx_s);
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;

    // Even parity wants an even count of ones over data+parity; odd wants an odd count.
    assign par_calc   = (^shreg) ^ par_bit;
    assign pe_now     = (PARITY == 0) ? 1'b0 : ((PARITY == 1) ? par_calc : ~par_calc);
    assign brk_par_ok = (PARITY == 0) ? 1'b1 : ~par_bit;
    assign fe_now     = ferr | ~vote;

    // Frame FSM: bit timing, shifting, error accumulation and registered frame outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idle       <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ferr       <= 1'b0;
            rx_data    <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_d && !rx_s) begin
                        cnt      <= CNT_TOP;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        shreg    <= '0;
                        par_bit  <= 1'b0;
                        ferr     <= 1'b0;
                        state    <= S_START;
                        idle     <= 1'b0;
                    end
                end
                S_START: begin
                    cnt <= tick_next;
                    // A start bit that is high at mid-bit was only a glitch.
                    if (decide && vote) begin
                        state <= S_IDLE;
                        idle  <= 1'b1;
                    end else if (at_zero) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    cnt <= tick_next;
                    if (decide) begin
                        shreg <= {vote, shreg[DATA_W-1:1]};
                    end
                    if (at_zero) begin
                        if (bit_idx == IDX_LAST) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + idx_t'(1);
                        end
                    end
                end
                S_PARITY: begin
                    cnt <= tick_next;
                    if (decide) begin
                        par_bit <= vote;
                    end
                    if (at_zero) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    cnt <= tick_next;
                    if (decide) begin
                        if (last_stop) begin
                            // Finish at mid stop bit so a back-to-back start edge is not missed.
                            valid      <= 1'b1;
                            rx_data    <= shreg;
                            parity_err <= pe_now;
                            frame_err  <= fe_now;
                            break_det  <= fe_now && (shreg == '0) && brk_par_ok;
                            state      <= vote ? S_IDLE : S_WAIT_HIGH;
                            idle       <= vote;
                        end else if (!vote) begin
                            ferr <= 1'b1;
                        end
                    end else if (at_zero) begin
                        stop_idx <= 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line must return high before a new start is accepted.
                    if (rx_s) begin
                        state <= S_IDLE;
                        idle  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 9O2) at 10 clocks per bit.
// Frames are driven bit by bit from negedges; a monitor latches each valid pulse.
// Expected values are hand-computed constants.
module tb_uart_rx_cfg;

    localparam int FCLK = 100;
    localparam int BAUD = 10;
    localparam int BT   = FCLK / BAUD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rxl   = 3'b111;

    always #5 clk = ~clk;

    logic [7:0] data0, data1;
    logic [8:0] data2;
    logic       vld0, pe0, fe0, bd0, idle0;
    logic       vld1, pe1, fe1, bd1, idle1;
    logic       vld2, pe2, fe2, bd2, idle2;

    uart_rx_cfg #(.FCLK(FCLK), .BAUD(BAUD), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_n81 (
        .clk(clk), .rst_n(rst_n), .rx(rxl[0]), .rx_data(data0), .valid(vld0),
        .parity_err(pe0), .frame_err(fe0), .break_det(bd0), .idle(idle0));

    uart_rx_cfg #(.FCLK(FCLK), .BAUD(BAUD), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) u_e81 (
        .clk(clk), .rst_n(rst_n), .rx(rxl[1]), .rx_data(data1), .valid(vld1),
        .parity_err(pe1), .frame_err(fe1), .break_det(bd1), .idle(idle1));

    uart_rx_cfg #(.FCLK(FCLK), .BAUD(BAUD), .DATA_W(9), .PARITY(2), .STOP_BITS(2)) u_o92 (
        .clk(clk), .rst_n(rst_n), .rx(rxl[2]), .rx_data(data2), .valid(vld2),
        .parity_err(pe2), .frame_err(fe2), .break_det(bd2), .idle(idle2));

    int         cnt0 = 0, cnt1 = 0, cnt2 = 0;
    logic [7:0] cdat0 = '0, cdat1 = '0;
    logic [8:0] cdat2 = '0;
    logic       cpe0 = 0, cfe0 = 0, cbd0 = 0;
    logic       cpe1 = 0, cfe1 = 0, cbd1 = 0;
    logic       cpe2 = 0, cfe2 = 0, cbd2 = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // Latch outputs of every valid pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (vld0) begin
            cnt0 <= cnt0 + 1; cdat0 <= data0; cpe0 <= pe0; cfe0 <= fe0; cbd0 <= bd0;
        end
        if (vld1) begin
            cnt1 <= cnt1 + 1; cdat1 <= data1; cpe1 <= pe1; cfe1 <= fe1; cbd1 <= bd1;
        end
        if (vld2) begin
            cnt2 <= cnt2 + 1; cdat2 <= data2; cpe2 <= pe2; cfe2 <= fe2; cbd2 <= bd2;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int line, input logic val, input int n);
        rxl[line] = val;
        repeat (n) @(negedge clk);
    endtask

    // Start bit, data LSB first, optional parity, stop bit(s); glitch >= 0 flips one cycle mid-bit.
    task automatic send(input int line, input logic [8:0] data, input int dw, input int has_par,
                        input logic par, input int nstop, input logic stop1, input logic stop2,
                        input int glitch);
        logic [15:0] v;
        int n;
        v = '0;
        for (int i = 0; i < dw; i++) v[1+i] = data[i];
        n = 1 + dw;
        if (has_par != 0) begin v[n] = par; n++; end
        v[n] = stop1; n++;
        if (nstop == 2) begin v[n] = stop2; n++; end
        for (int i = 0; i < n; i++) begin
            if (i == glitch) begin
                drive(line, v[i], 5);
                drive(line, ~v[i], 1);
                drive(line, v[i], BT - 6);
            end else begin
                drive(line, v[i], BT);
            end
        end
    endtask

    int b;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", data0, 0);
        check("rst_valid", vld0, 0);
        check("rst_idle", idle0, 1);
        check("rst_ferr", fe0, 0);
        check("rst_brk", bd0, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Back-to-back 8N1 frames, no idle gap
        b = cnt0;
        send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        check("b2b1_cnt", cnt0 - b, 1);
        check("b2b1_data", cdat0, 'hA5);
        check("b2b1_err", {cpe0, cfe0, cbd0}, 0);
        send(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        check("b2b2_cnt", cnt0 - b, 2);
        check("b2b2_data", cdat0, 'h3C);
        check("b2b2_err", {cpe0, cfe0, cbd0}, 0);
        drive(0, 1'b1, 2 * BT);

        // Even parity: 0x07 has three ones, so parity bit 1 is correct
        b = cnt1;
        send(1, 9'h007, 8, 1, 1'b1, 1, 1'b1, 1'b1, -1);
        check("even_ok_cnt", cnt1 - b, 1);
        check("even_ok_data", cdat1, 'h07);
        check("even_ok_pe", cpe1, 0);
        send(1, 9'h007, 8, 1, 1'b0, 1, 1'b1, 1'b1, -1);
        check("even_bad_cnt", cnt1 - b, 2);
        check("even_bad_data", cdat1, 'h07);
        check("even_bad_pe", cpe1, 1);
        check("even_bad_fe", cfe1, 0);
        drive(1, 1'b1, 2 * BT);

        // Stop bit low with non-zero data: framing error, not a break
        b = cnt0;
        send(0, 9'h055, 8, 0, 1'b0, 1, 1'b0, 1'b1, -1);
        drive(0, 1'b1, 2 * BT);
        check("stop0_cnt", cnt0 - b, 1);
        check("stop0_data", cdat0, 'h55);
        check("stop0_fe", cfe0, 1);
        check("stop0_bd", cbd0, 0);

        // Line held low for 20 bit times: exactly one break frame
        b = cnt0;
        drive(0, 1'b0, 20 * BT);
        check("brk_cnt", cnt0 - b, 1);
        check("brk_data", cdat0, 0);
        check("brk_fe", cfe0, 1);
        check("brk_bd", cbd0, 1);
        check("brk_wait_idle", idle0, 0);
        drive(0, 1'b1, 2 * BT);
        check("brk_after_cnt", cnt0 - b, 1);
        check("brk_after_idle", idle0, 1);
        send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        check("post_brk_cnt", cnt0 - b, 2);
        check("post_brk_data", cdat0, 'h5A);
        check("post_brk_err", {cfe0, cbd0}, 0);
        drive(0, 1'b1, BT);

        // Three-cycle low pulse: rejected as a false start
        b = cnt0;
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 3 * BT);
        check("fstart_cnt", cnt0 - b, 0);
        check("fstart_idle", idle0, 1);

        // Reset during data bit 4 of 0x81
        b = cnt0;
        drive(0, 1'b0, BT);
        drive(0, 1'b1, BT);
        drive(0, 1'b0, 3 * BT);
        drive(0, 1'b0, 5);
        rst_n = 1'b0;
        rxl[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_data", data0, 0);
        check("mrst_idle", idle0, 1);
        check("mrst_valid", vld0, 0);
        rst_n = 1'b1;
        drive(0, 1'b1, 2 * BT);
        check("mrst_cnt", cnt0 - b, 0);
        send(0, 9'h081, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        check("mrst_next_cnt", cnt0 - b, 1);
        check("mrst_next_data", cdat0, 'h81);
        drive(0, 1'b1, BT);

        // One-cycle high glitch mid data bit 3 of 0x00 is voted out
        b = cnt0;
        send(0, 9'h000, 8, 0, 1'b0, 1, 1'b1, 1'b1, 4);
        check("glitch_cnt", cnt0 - b, 1);
        check("glitch_data", cdat0, 'h00);
        drive(0, 1'b1, BT);

        // 9 data bits, odd parity, two stop bits
        b = cnt2;
        send(2, 9'h1FF, 9, 1, 1'b0, 2, 1'b1, 1'b1, -1);
        check("odd_cnt", cnt2 - b, 1);
        check("odd_data", cdat2, 'h1FF);
        check("odd_pe", cpe2, 0);
        check("odd_fe", cfe2, 0);
        send(2, 9'h1FF, 9, 1, 1'b0, 2, 1'b1, 1'b0, -1);
        drive(2, 1'b1, 2 * BT);
        check("stop2_cnt", cnt2 - b, 2);
        check("stop2_data", cdat2, 'h1FF);
        check("stop2_fe", cfe2, 1);
        check("stop2_pe", cpe2, 0);
        check("stop2_bd", cbd2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
